johnson_counter_param: RTL

Parametrised Johnson (twisted-ring) counter: the next generation of the team's fixed 4-bit Johnson counter. Adds configurable width, count enable, up/down direction, parallel load, a binary phase index, a wrap pulse, and optional illegal-state self-correction. Used as a glitch-free multiphase sequence and clock-phase generator in the sequential library.

---
 rtl/johnson_counter_param.sv | 45 ++++
 1 files changed

// File: rtl/johnson_counter_param.sv
// johnson_counter_param: N-bit Johnson counter with enable, direction, load, phase index, wrap pulse and optional self-correction (JOHNSON_SELF_CORRECT_EN)
module johnson_counter_param #(
  parameter int N  = 4,
  parameter int PW = $clog2(2 * N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          up,
  input  logic          load,
  input  logic [N-1:0]  load_val,
  output logic [N-1:0]  count,
  output logic [PW-1:0] phase,
  output logic          wrap,
  output logic          err
);
  logic [N-1:0] step;
  logic         wrap_hit;
  logic         illegal;
  logic [PW:0]  pop;
  assign step     = up ? {count[N-2:0], ~count[N-1]} : {~count[0], count[N-1:1]};
  assign wrap_hit = up ? (count == {1'b1, {(N-1){1'b0}}}) : (count == '0);
`ifdef JOHNSON_SELF_CORRECT_EN
  assign illegal = (|((count + N'(1)) & count)) && (|((~count + N'(1)) & ~count));
`else
  assign illegal = 1'b0;
`endif
  // phase index: ones from the LSB count upward, ones from the MSB count down from 2N
  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) pop = pop + {{PW{1'b0}}, count[i]};
    phase = count[N-1] ? PW'(2 * N - int'(pop)) : PW'(pop);
  end
  // state register: load beats correction beats stepping; pulses only on their own event
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
      err   <= 1'b0;
    end else begin
      count <= load ? load_val : illegal ? '0 : en ? step : count;
      wrap  <= !load && !illegal && en && wrap_hit;
      err   <= !load && illegal;
    end
endmodule
